// File: rtl/count_ctrl.sv
// count_ctrl: command-driven sequencer around a WIDTH-bit up-counter.
// Commands START/STOP/RESUME/CLEAR arrive on a valid/ready handshake.
// The block counts from 0 to a programmable terminal count in one-shot
// or periodic mode, and emits a registered one-cycle match pulse.
module count_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_periodic,
  output logic [WIDTH-1:0] cnt,
  output logic             running,
  output logic             done,
  output logic             match,
  output logic [1:0]       dbg_state
);

  // Handshake: a command is accepted at a rising edge when cmd_valid and
  // cmd_ready are both high. cmd_ready is registered and drops for exactly
  // one cycle after every accept, so at most one command lands every two
  // cycles. The host must hold cmd_valid and the payload until accepted.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_limit;
  logic             r_periodic;
  logic             r_match;
  logic             r_ready;

  logic w_accept;
  logic w_at_limit;

  assign w_accept   = cmd_valid && r_ready;
  assign w_at_limit = (r_cnt == r_limit);

  // Single FSM: commands take precedence over counting at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_limit    <= '0;
      r_periodic <= 1'b0;
      r_match    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_match <= 1'b0;
      if (w_accept) begin
        r_ready <= 1'b0;
        case (cmd_op)
          OP_START: begin
            r_limit    <= cmd_data;
            r_periodic <= cmd_periodic;
            r_cnt      <= '0;
            r_state    <= S_RUN;
          end
          OP_STOP: begin
            if (r_state == S_RUN) r_state <= S_HOLD;
          end
          OP_RESUME: begin
            if (r_state == S_HOLD) r_state <= S_RUN;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_ready <= 1'b1;
        if (r_state == S_RUN) begin
          if (w_at_limit) begin
            r_match <= 1'b1;
            if (r_periodic) begin
              r_cnt <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready = r_ready;
  assign cnt       = r_cnt;
  assign match     = r_match;
  assign running   = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed and randomized stimulus for count_ctrl, checked
// every cycle against a behavioural model that tracks the number of
// counting edges since START and derives cnt/match arithmetically.
module tb_count_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         cmd_periodic;
  logic [W-1:0] cnt;
  logic         running;
  logic         done;
  logic         match;
  logic [1:0]   dbg_state;

  count_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_periodic (cmd_periodic),
    .cnt          (cnt),
    .running      (running),
    .done         (done),
    .match        (match),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, RESUME = 2'b10, CLEAR = 2'b11;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  // ---------------- reference model ----------------
  int          n_vec;
  int          n_err;
  int          m_mode;
  longint      m_n;        // counting edges since the last START
  longint      m_limit;
  logic        m_periodic;
  logic        m_ready;
  logic        m_match;

  function automatic longint exp_cnt();
    if (m_mode == M_IDLE) return 0;
    if (m_mode == M_DONE) return m_limit;
    if (m_periodic) return m_n % (m_limit + 1);
    return m_n;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_limit = 0; m_periodic = 1'b0;
    m_ready = 1'b1; m_match = 1'b0;
  endtask

  // Applied at each rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = cmd_valid && m_ready;
    m_match = 1'b0;
    if (acc) begin
      m_ready = 1'b0;
      case (cmd_op)
        START: begin
          m_limit = longint'(cmd_data); m_periodic = cmd_periodic;
          m_n = 0; m_mode = M_RUN;
        end
        STOP:    if (m_mode == M_RUN)  m_mode = M_HOLD;
        RESUME:  if (m_mode == M_HOLD) m_mode = M_RUN;
        default: begin m_n = 0; m_mode = M_IDLE; end
      endcase
    end else begin
      m_ready = 1'b1;
      if (m_mode == M_RUN) begin
        m_n++;
        if (m_n % (m_limit + 1) == 0) begin
          m_match = 1'b1;
          if (!m_periodic) m_mode = M_DONE;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt",       {32'd0, cnt},       64'(exp_cnt()));
    chk("running",   {63'd0, running},   {63'd0, m_mode == M_RUN});
    chk("done",      {63'd0, done},      {63'd0, m_mode == M_DONE});
    chk("match",     {63'd0, match},     {63'd0, m_match});
    chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, m_ready});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                       input logic [W-1:0] d, input logic p);
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_periodic = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, START, '0, 1'b0);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [W-1:0] d, input logic p);
    cycle(1'b0, 1'b1, op, d, p);
  endtask

  // Idles until the model says cnt reaches target; an expired budget is a miscompare.
  task automatic run_to(input longint target, input int budget);
    int b;
    b = budget;
    while (exp_cnt() != target && b > 0) begin
      idle(1);
      b--;
    end
    chk("run_to_budget", {63'd0, exp_cnt() == target}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = START; cmd_data = '0; cmd_periodic = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, START, '0, 1'b0);
    cycle(1'b1, 1'b0, START, '0, 1'b0);
    idle(2);

    // One-shot L=9, then 50 quiet cycles
    cmd(START, 32'd9, 1'b0);
    idle(12);
    chk("oneshot_done", {63'd0, done}, 64'd1);
    chk("oneshot_hold", {32'd0, cnt}, 64'd9);
    idle(50);

    // Periodic L=4 over four-plus periods
    cmd(START, 32'd4, 1'b1);
    idle(22);
    chk("periodic_running", {63'd0, running}, 64'd1);

    // STOP at 20 of L=100, hold 30 cycles, RESUME through the match
    cmd(START, 32'd100, 1'b0);
    run_to(20, 40);
    cmd(STOP, '0, 1'b0);
    idle(30);
    chk("hold_cnt", {32'd0, cnt}, 64'd20);
    cmd(RESUME, '0, 1'b0);
    idle(90);

    // STOP exactly at terminal count suppresses the match; RESUME matches next edge
    cmd(START, 32'd7, 1'b0);
    run_to(7, 20);
    cmd(STOP, '0, 1'b0);
    idle(4);
    cmd(RESUME, '0, 1'b0);
    idle(3);

    // Handshake: valid held three cycles, START then CLEAR
    idle(1);
    cmd(START, 32'd30, 1'b1);
    cmd(CLEAR, '0, 1'b0);
    cmd(CLEAR, '0, 1'b0);
    idle(2);
    chk("hs_idle_cnt", {32'd0, cnt}, 64'd0);
    chk("hs_idle_run", {63'd0, running}, 64'd0);

    // Reset mid-run with a command presented during reset
    cmd(START, 32'd200, 1'b1);
    run_to(50, 60);
    cycle(1'b1, 1'b1, START, 32'd5, 1'b1);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_cnt", {32'd0, cnt}, 64'd0);
    idle(3);

    // L=0 periodic and one-shot, L=all-ones briefly, no-op commands
    cmd(START, 32'd0, 1'b1);
    idle(5);
    cmd(START, 32'd0, 1'b0);
    idle(3);
    cmd(START, 32'hFFFF_FFFF, 1'b1);
    idle(6);
    cmd(CLEAR, '0, 1'b0);
    idle(1);
    cmd(RESUME, '0, 1'b0);
    idle(1);
    cmd(STOP, '0, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3)
        cmd(2'($urandom_range(0, 3)), W'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      else
        idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
